reg_bank: RTL and testbench

- Parametrised successor to the single accumulator register: DEPTH general-purpose registers of WIDTH bits behind one bus port.
- Adds addressed selection, in-place INC/DEC/CLR, and carry/zero flags.
- Sits on the CPU data bus, driven by the control unit via a `reg_bank_op_e` opcode and a register select.
- Single clock edge (posedge) for all state. No tri-state: the driven bus value is `out` qualified by `out_en`, and bus muxing happens upstream.

---
 rtl/reg_bank_pkg.sv | 24 ++
 rtl/reg_bank_alu.sv | 62 ++++++
 rtl/reg_bank.sv | 87 ++++++++
 tb/tb_reg_bank.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_pkg.sv
// Shared types for the register bank: opcode enum and default sizing.
// The REG_BANK_SHIFT_EN macro (see reg_bank_alu) enables SHL/SHR.
package reg_bank_pkg;

   typedef enum logic [2:0] {
      NOP    = 3'd0,
      LOAD   = 3'd1,
      ENABLE = 3'd2,
      INC    = 3'd3,
      DEC    = 3'd4,
      CLR    = 3'd5,
      SHL    = 3'd6,
      SHR    = 3'd7
   } reg_bank_op_e;

   localparam int REG_BANK_DEPTH_DEFAULT = 4;
   localparam int REG_BANK_WIDTH_DEFAULT = 8;

   // Select width never drops below one bit, even for a single register.
   function automatic int sel_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/reg_bank_alu.sv
// Combinational next-value logic for one register of the bank.
// Define REG_BANK_SHIFT_EN to enable SHL/SHR; otherwise they act as NOP.
module reg_bank_alu
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = REG_BANK_WIDTH_DEFAULT
) (
   input  logic [WIDTH-1:0] old,
   input  logic [WIDTH-1:0] in,
   input  reg_bank_op_e     op,
   output logic [WIDTH-1:0] result,
   output logic             carry_next,
   output logic             carry_we,
   output logic             we
);

   always_comb begin
      result     = old;
      carry_next = 1'b0;
      carry_we   = 1'b0;
      we         = 1'b0;
      unique case (op)
         LOAD: begin
            result = in;
            we     = 1'b1;
         end
         INC: begin
            {carry_next, result} = {1'b0, old} + (WIDTH+1)'(1);
            carry_we = 1'b1;
            we       = 1'b1;
         end
         // Borrow shows up as the extra top bit going high.
         DEC: begin
            {carry_next, result} = {1'b0, old} - (WIDTH+1)'(1);
            carry_we = 1'b1;
            we       = 1'b1;
         end
         CLR: begin
            result   = '0;
            carry_we = 1'b1;
            we       = 1'b1;
         end
`ifdef REG_BANK_SHIFT_EN
         SHL: begin
            result     = old << 1;
            carry_next = old[WIDTH-1];
            carry_we   = 1'b1;
            we         = 1'b1;
         end
         SHR: begin
            result     = old >> 1;
            carry_next = old[0];
            carry_we   = 1'b1;
            we         = 1'b1;
         end
`endif
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register bank with INC/DEC/CLR, carry/zero flags and bus read.
// Shift ops are present only when REG_BANK_SHIFT_EN is defined.
module reg_bank
   import reg_bank_pkg::*;
#(
   parameter int  WIDTH = REG_BANK_WIDTH_DEFAULT,
   parameter int  DEPTH = REG_BANK_DEPTH_DEFAULT,
   localparam int SEL_W = sel_width(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in,
   input  reg_bank_op_e           op,
   input  logic [SEL_W-1:0]       sel,
   output logic [WIDTH-1:0]       out,
   output logic                   out_en,
   output logic                   carry,
   output logic                   zero,
   output logic [DEPTH*WIDTH-1:0] reg_direct
);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] old;
   logic [DEPTH-1:0] hit;
   logic             in_range;
   logic [WIDTH-1:0] result;
   logic             carry_next;
   logic             carry_we;
   logic             we;

   // One-hot decode of sel; an out-of-range sel hits nothing and reads 0.
   always_comb begin
      old = '0;
      hit = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (sel == SEL_W'(i)) begin
            old    = regs[i];
            hit[i] = 1'b1;
         end
      end
   end

   assign in_range = |hit;

   reg_bank_alu #(
      .WIDTH(WIDTH)
   ) u_alu (
      .old       (old),
      .in        (in),
      .op        (op),
      .result    (result),
      .carry_next(carry_next),
      .carry_we  (carry_we),
      .we        (we)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
         out    <= '0;
         out_en <= 1'b0;
         carry  <= 1'b0;
         zero   <= 1'b1;
      end else begin
         out    <= (op == ENABLE) ? old : '0;
         out_en <= (op == ENABLE);
         for (int i = 0; i < DEPTH; i++) begin
            if (we && hit[i]) begin
               regs[i] <= result;
            end
         end
         if (we && in_range) begin
            zero <= (result == '0);
            if (carry_we) begin
               carry <= carry_next;
            end
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_direct
      assign reg_direct[g*WIDTH +: WIDTH] = regs[g];
   end

endmodule

// File: tb/tb_reg_bank.sv
// Randomised and directed bench for reg_bank (WIDTH=8, DEPTH=4) with a
// second DEPTH=3 instance for out-of-range selects.
module tb_reg_bank;
   import reg_bank_pkg::*;

   logic         clock = 1'b0;
   logic         reset;
   logic [7:0]   in;
   reg_bank_op_e op;
   logic [1:0]   sel;
   logic [7:0]   out;
   logic         out_en;
   logic         carry;
   logic         zero;
   logic [31:0]  reg_direct;

   logic [1:0]   sel3;
   logic [7:0]   out3;
   logic         out_en3;
   logic         carry3;
   logic         zero3;
   logic [23:0]  reg_direct3;

   int checks   = 0;
   int failures = 0;

   int m_reg [4];
   bit m_carry;
   bit m_zero;
   bit m_en;
   int m_out;

   always #5 clock = ~clock;

   reg_bank #(.WIDTH(8), .DEPTH(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .in        (in),
      .op        (op),
      .sel       (sel),
      .out       (out),
      .out_en    (out_en),
      .carry     (carry),
      .zero      (zero),
      .reg_direct(reg_direct)
   );

   reg_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
      .clock     (clock),
      .reset     (reset),
      .in        (in),
      .op        (op),
      .sel       (sel3),
      .out       (out3),
      .out_en    (out_en3),
      .carry     (carry3),
      .zero      (zero3),
      .reg_direct(reg_direct3)
   );

   function automatic logic [31:0] m_direct();
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = m_reg[i][7:0];
      return v;
   endfunction

   // Drive one op through a clock edge and advance the reference model.
   task automatic step(input reg_bank_op_e o, input int s,
                       input int d, input bit r);
      op    = o;
      sel   = s[1:0];
      in    = d[7:0];
      reset = r;
      @(posedge clock);
      #1;
      if (r) begin
         for (int i = 0; i < 4; i++) m_reg[i] = 0;
         m_carry = 0;
         m_zero  = 1;
         m_en    = 0;
         m_out   = 0;
      end else begin
         m_en  = 0;
         m_out = 0;
         case (o)
            LOAD: begin
               m_reg[s] = d % 256;
               m_zero   = (m_reg[s] == 0);
            end
            ENABLE: begin
               m_en  = 1;
               m_out = m_reg[s];
            end
            INC: begin
               m_carry  = (m_reg[s] == 255);
               m_reg[s] = (m_reg[s] + 1) % 256;
               m_zero   = (m_reg[s] == 0);
            end
            DEC: begin
               m_carry  = (m_reg[s] == 0);
               m_reg[s] = (m_reg[s] + 255) % 256;
               m_zero   = (m_reg[s] == 0);
            end
            CLR: begin
               m_reg[s] = 0;
               m_carry  = 0;
               m_zero   = 1;
            end
`ifdef REG_BANK_SHIFT_EN
            SHL: begin
               m_carry  = (m_reg[s] >= 128);
               m_reg[s] = (m_reg[s] * 2) % 256;
               m_zero   = (m_reg[s] == 0);
            end
            SHR: begin
               m_carry  = (m_reg[s] % 2) == 1;
               m_reg[s] = m_reg[s] / 2;
               m_zero   = (m_reg[s] == 0);
            end
`endif
            default: begin
            end
         endcase
      end
   endtask

   task automatic test_reset();
      step(NOP, 0, 0, 1);
      checks++;
      if (reg_direct !== 32'h0) begin
         failures++;
         $display("FAIL reset_regs: got %h want %h", reg_direct, 32'h0);
      end
      checks++;
      if (zero !== 1'b1 || carry !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags: got z=%b c=%b want z=1 c=0", zero, carry);
      end
      checks++;
      if (out_en !== 1'b0 || out !== 8'h00) begin
         failures++;
         $display("FAIL reset_out: got %h/%b want 00/0", out, out_en);
      end
      step(ENABLE, 2, 0, 0);
      checks++;
      if (out !== 8'h00 || out_en !== 1'b1) begin
         failures++;
         $display("FAIL reset_read: got %h/%b want 00/1", out, out_en);
      end
   endtask

   task automatic test_load_read();
      step(LOAD, 1, 'hA5, 0);
      checks++;
      if (reg_direct[15:8] !== 8'hA5 || zero !== 1'b0) begin
         failures++;
         $display("FAIL load: got %h z=%b want a5 z=0", reg_direct[15:8], zero);
      end
      step(ENABLE, 1, 0, 0);
      checks++;
      if (out !== 8'hA5 || out_en !== 1'b1) begin
         failures++;
         $display("FAIL read: got %h/%b want a5/1", out, out_en);
      end
      step(NOP, 1, 0, 0);
      checks++;
      if (out !== 8'h00 || out_en !== 1'b0) begin
         failures++;
         $display("FAIL read_end: got %h/%b want 00/0", out, out_en);
      end
   endtask

   task automatic test_inc_wrap();
      step(LOAD, 0, 'hFF, 0);
      step(INC, 0, 0, 0);
      checks++;
      if (reg_direct[7:0] !== 8'h00 || carry !== 1'b1 || zero !== 1'b1) begin
         failures++;
         $display("FAIL inc_wrap: got %h c=%b z=%b want 00 c=1 z=1",
                  reg_direct[7:0], carry, zero);
      end
      step(INC, 0, 0, 0);
      checks++;
      if (reg_direct[7:0] !== 8'h01 || carry !== 1'b0 || zero !== 1'b0) begin
         failures++;
         $display("FAIL inc_again: got %h c=%b z=%b want 01 c=0 z=0",
                  reg_direct[7:0], carry, zero);
      end
   endtask

   task automatic test_dec_borrow();
      step(CLR, 3, 0, 0);
      checks++;
      if (reg_direct[31:24] !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
         failures++;
         $display("FAIL clr: got %h c=%b z=%b want 00 c=0 z=1",
                  reg_direct[31:24], carry, zero);
      end
      step(DEC, 3, 0, 0);
      checks++;
      if (reg_direct[31:24] !== 8'hFF || carry !== 1'b1 || zero !== 1'b0) begin
         failures++;
         $display("FAIL dec_borrow: got %h c=%b z=%b want ff c=1 z=0",
                  reg_direct[31:24], carry, zero);
      end
   endtask

   task automatic test_reset_mid();
      step(ENABLE, 3, 0, 0);
      step(LOAD, 2, 'h3C, 1);
      checks++;
      if (reg_direct !== 32'h0) begin
         failures++;
         $display("FAIL reset_mid_regs: got %h want 0", reg_direct);
      end
      checks++;
      if (zero !== 1'b1 || carry !== 1'b0 || out_en !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_flags: got z=%b c=%b en=%b want 1/0/0",
                  zero, carry, out_en);
      end
   endtask

   task automatic test_shift();
      logic [7:0] exp_r;
      logic       exp_c;
`ifdef REG_BANK_SHIFT_EN
      exp_r = 8'h02;
      exp_c = 1'b1;
`else
      exp_r = 8'h81;
      exp_c = 1'b0;
`endif
      step(CLR, 1, 0, 0);
      step(LOAD, 1, 'h81, 0);
      step(SHL, 1, 0, 0);
      checks++;
      if (reg_direct[15:8] !== exp_r || carry !== exp_c) begin
         failures++;
         $display("FAIL shl: got %h c=%b want %h c=%b",
                  reg_direct[15:8], carry, exp_r, exp_c);
      end
      step(SHR, 1, 0, 0);
      checks++;
      if (reg_direct[15:8] !== m_direct()[15:8] || carry !== m_carry) begin
         failures++;
         $display("FAIL shr: got %h c=%b want %h c=%b",
                  reg_direct[15:8], carry, m_direct()[15:8], m_carry);
      end
   endtask

   task automatic test_back_to_back();
      int vals [4];
      for (int i = 0; i < 4; i++) begin
         vals[i] = $urandom_range(1, 255);
         step(LOAD, i, vals[i], 0);
      end
      for (int i = 0; i < 4; i++) begin
         step(ENABLE, 3 - i, 0, 0);
         checks++;
         if (out !== vals[3-i][7:0] || out_en !== 1'b1) begin
            failures++;
            $display("FAIL b2b_read%0d: got %h/%b want %h/1",
                     i, out, out_en, vals[3-i][7:0]);
         end
      end
      step(INC, 0, 0, 0);
      checks++;
      if (out !== 8'h00 || out_en !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end: got %h/%b want 00/0", out, out_en);
      end
   endtask

   task automatic test_out_of_range();
      sel3 = 2'd0;
      step(NOP, 0, 0, 1);
      sel3 = 2'd3;
      step(LOAD, 0, 'h55, 0);
      checks++;
      if (reg_direct3 !== 24'h0 || zero3 !== 1'b1) begin
         failures++;
         $display("FAIL oor_load: got %h z=%b want 0 z=1", reg_direct3, zero3);
      end
      step(DEC, 0, 0, 0);
      checks++;
      if (reg_direct3 !== 24'h0 || carry3 !== 1'b0 || zero3 !== 1'b1) begin
         failures++;
         $display("FAIL oor_dec: got %h c=%b z=%b want 0 c=0 z=1",
                  reg_direct3, carry3, zero3);
      end
      sel3 = 2'd2;
      step(LOAD, 0, 'h77, 0);
      sel3 = 2'd3;
      step(ENABLE, 0, 0, 0);
      checks++;
      if (out3 !== 8'h00 || out_en3 !== 1'b1) begin
         failures++;
         $display("FAIL oor_read: got %h/%b want 00/1", out3, out_en3);
      end
      sel3 = 2'd2;
      step(ENABLE, 0, 0, 0);
      checks++;
      if (out3 !== 8'h77 || reg_direct3[23:16] !== 8'h77) begin
         failures++;
         $display("FAIL top_read: got %h reg=%h want 77",
                  out3, reg_direct3[23:16]);
      end
      sel3 = 2'd0;
   endtask

   task automatic test_random();
      reg_bank_op_e o;
      int d;
      for (int n = 0; n < 400; n++) begin
         o = reg_bank_op_e'($urandom_range(0, 7));
         case ($urandom_range(0, 3))
            0:       d = 0;
            1:       d = 255;
            default: d = $urandom_range(0, 255);
         endcase
         step(o, $urandom_range(0, 3), d, ($urandom_range(0, 49) == 0));
         checks++;
         if (reg_direct !== m_direct()) begin
            failures++;
            $display("FAIL rnd_regs@%0d: got %h want %h", n, reg_direct, m_direct());
         end
         checks++;
         if (carry !== m_carry || zero !== m_zero) begin
            failures++;
            $display("FAIL rnd_flags@%0d: got c=%b z=%b want c=%b z=%b",
                     n, carry, zero, m_carry, m_zero);
         end
         checks++;
         if (out !== m_out[7:0] || out_en !== m_en) begin
            failures++;
            $display("FAIL rnd_out@%0d: got %h/%b want %h/%b",
                     n, out, out_en, m_out[7:0], m_en);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      in    = '0;
      op    = NOP;
      sel   = '0;
      sel3  = '0;
      test_reset();
      test_load_read();
      test_inc_wrap();
      test_dec_borrow();
      test_reset_mid();
      test_shift();
      test_back_to_back();
      test_out_of_range();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
